// File: rtl/uart_imem_loader_pkg.sv
// Shared types and helpers for the UART instruction-memory boot loader.
// L_CHK exists only when UART_IMEM_LOADER_CHECKSUM_EN is defined.
package uart_imem_loader_pkg;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_t;

    typedef enum logic [2:0] {
        LLenLo,
        LLenHi,
        LData,
        LRun
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        ,
        LChk
`endif
    } loader_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned freq,
                                                 input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, start-bit qualification at mid-bit,
// one-cycle byte_valid on a good stop bit and one-cycle frame_err on a bad one.
module uart_rx
    import uart_imem_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_fall;
    logic             w_tick;

    assign w_fall = r_prev & ~r_sync2;
    // Start bit is checked half a bit in; every later sample is a full bit apart.
    assign w_tick = (r_state == RxStart) ? (r_cnt == HALF_M1) : (r_cnt == FULL_M1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RxIdle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RxIdle:  if (w_fall) w_next = RxStart;
            RxStart: if (w_tick) w_next = r_sync2 ? RxIdle : RxData;
            RxData:  if (w_tick && (r_bit_idx == 3'd7)) w_next = RxStop;
            RxStop:  if (w_tick) w_next = RxIdle;
            default: w_next = RxIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if ((r_state == RxIdle) || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == RxStart) begin
                r_bit_idx <= '0;
            end
            if ((r_state == RxData) && w_tick) begin
                r_shift   <= {r_sync2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        o_byte       = r_shift;
        o_byte_valid = 1'b0;
        o_frame_err  = 1'b0;
        if ((r_state == RxStop) && w_tick) begin
            o_byte_valid = r_sync2;
            o_frame_err  = ~r_sync2;
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: length-prefixed UART image -> little-endian words -> imem, holding the core
// until the image completes. Define UART_IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned IMEM_DEPTH  = 1024,
    localparam int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [16:0] DEPTH_W = 17'(IMEM_DEPTH);

    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_frame_err;

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [15:0]       r_word_cnt;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_shift;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic              r_hold;
    logic              r_fin;
    logic              r_done;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_take_len_lo;
    logic              w_len_zero;
    logic              w_word_end;
    logic              w_last_word;
    logic              w_finish;
    logic              w_reload;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_byte      (w_byte),
        .o_byte_valid(w_byte_valid),
        .o_frame_err (w_frame_err)
    );

    assign w_word        = {w_byte, r_shift};
    assign w_reload      = (r_state == LRun) && w_byte_valid;
    assign w_take_len_lo = w_byte_valid && ((r_state == LLenLo) || (r_state == LRun));
    assign w_len_zero    = (r_state == LLenHi) && w_byte_valid && ({w_byte, r_len_lo} == 16'd0);
    assign w_word_end    = (r_state == LData) && w_byte_valid && (r_byte_cnt == 2'd3);
    assign w_last_word   = w_word_end && (r_word_cnt == (r_len - 16'd1));

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_chk;
    logic       w_chk_ok;
    logic       w_chk_bad;

    assign w_chk_ok  = (r_state == LChk) && w_byte_valid && (w_byte == r_chk);
    assign w_chk_bad = (r_state == LChk) && w_byte_valid && (w_byte != r_chk);
    assign w_finish  = w_chk_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= '0;
        end else if (w_take_len_lo) begin
            r_chk <= w_byte;
        end else if (w_byte_valid && ((r_state == LLenHi) || (r_state == LData))) begin
            r_chk <= r_chk ^ w_byte;
        end
    end
`else
    assign w_finish = w_last_word | w_len_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LLenLo;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LLenLo: if (w_byte_valid) w_next = LLenHi;
            LLenHi: begin
                if (w_byte_valid) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                    w_next = w_len_zero ? LChk : LData;
`else
                    w_next = w_len_zero ? LRun : LData;
`endif
                end
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            LData:  if (w_last_word) w_next = LChk;
            LChk:   if (w_byte_valid) w_next = w_chk_ok ? LRun : LLenLo;
`else
            LData:  if (w_last_word) w_next = LRun;
`endif
            LRun:   if (w_byte_valid) w_next = LLenHi;
            default: w_next = LLenLo;
        endcase
    end

    // Hold rises combinationally so the core stops in the very cycle a new image starts.
    always_comb begin
        imem_we    = r_we;
        imem_addr  = r_addr;
        imem_wdata = r_wdata;
        load_done  = r_done;
        err        = r_err;
        cpu_hold   = r_hold | w_reload;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_hold     <= 1'b1;
            r_fin      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_fin  <= w_finish;
            r_done <= r_fin;
            if (r_fin) begin
                r_hold <= 1'b0;
            end
            if (w_reload) begin
                r_hold <= 1'b1;
            end
            if (w_frame_err) begin
                r_err <= 1'b1;
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            if (w_chk_bad) begin
                r_err <= 1'b1;
            end
`endif
            // Address moves the cycle after the strobe and sticks at the top word.
            if (w_take_len_lo) begin
                r_len_lo <= w_byte;
                r_addr   <= '0;
            end else if (r_we && (r_addr != ADDR_MAX)) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if ((r_state == LLenHi) && w_byte_valid) begin
                r_len      <= {w_byte, r_len_lo};
                r_word_cnt <= '0;
                r_byte_cnt <= '0;
            end
            if ((r_state == LData) && w_byte_valid) begin
                r_shift    <= {w_byte, r_shift[23:8]};
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
            if (w_word_end) begin
                r_wdata    <= w_word;
                r_we       <= ({1'b0, r_word_cnt} < DEPTH_W);
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Randomized self-checking bench: serialises images onto rx and compares every imem write,
// completion pulse and hold/err level with a word-list model of the image format.
module tb_uart_imem_loader;

    localparam int unsigned CPB     = 10;
    localparam int unsigned DEPTH_A = 16;
    localparam int unsigned DEPTH_B = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_a;
    logic        rx_b;
    logic        a_we, a_hold, a_done, a_err;
    logic [3:0]  a_addr;
    logic [31:0] a_wdata;
    logic        b_we, b_hold, b_done, b_err;
    logic [0:0]  b_addr;
    logic [31:0] b_wdata;

    int          n_checks = 0;
    int          n_errors = 0;
    int          a_we_cnt = 0;
    int          a_done_cnt = 0;
    int          b_done_cnt = 0;
    logic        a_hold_prev = 1'b1;
    logic        a_we_prev = 1'b0;
    logic        a_exp_we_prev = 1'b0;
    logic        exp_err = 1'b0;
    wr_t         exp_a[$];
    wr_t         exp_b[$];
    wr_t         ea;
    wr_t         eb;
    logic [31:0] img_words[16];

    always #5 clk = ~clk;

    uart_imem_loader #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD       (100_000),
        .IMEM_DEPTH (DEPTH_A)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_a),
        .imem_we   (a_we),
        .imem_addr (a_addr),
        .imem_wdata(a_wdata),
        .cpu_hold  (a_hold),
        .load_done (a_done),
        .err       (a_err)
    );

    uart_imem_loader #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD       (100_000),
        .IMEM_DEPTH (DEPTH_B)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx_b),
        .imem_we   (b_we),
        .imem_addr (b_addr),
        .imem_wdata(b_wdata),
        .cpu_hold  (b_hold),
        .load_done (b_done),
        .err       (b_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_we) begin
            a_we_cnt <= a_we_cnt + 1;
            if (exp_a.size() == 0) begin
                check_eq("a_we_unexpected", 32'(a_we), 32'd0);
            end else begin
                ea = exp_a.pop_front();
                check_eq("a_addr", 32'(a_addr), ea.addr);
                check_eq("a_wdata", a_wdata, ea.data);
            end
        end
        if (a_done) begin
            a_done_cnt <= a_done_cnt + 1;
            check_eq("a_done_hold", 32'(a_hold), 32'd0);
            check_eq("a_done_prev_hold", 32'(a_hold_prev), 32'd1);
            check_eq("a_done_after_we", 32'(a_we_prev), 32'(a_exp_we_prev));
        end
        if (dut_a.w_byte_valid && !a_hold_prev) begin
            check_eq("a_hold_rise", 32'(a_hold), 32'd1);
        end
        a_hold_prev <= a_hold;
        a_we_prev   <= a_we;
    end

    always @(negedge clk) begin
        if (b_we) begin
            if (exp_b.size() == 0) begin
                check_eq("b_we_unexpected", 32'(b_we), 32'd0);
            end else begin
                eb = exp_b.pop_front();
                check_eq("b_addr", 32'(b_addr), eb.addr);
                check_eq("b_wdata", b_wdata, eb.data);
            end
        end
        if (b_done) begin
            b_done_cnt <= b_done_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive_rx(sel, frame[i]);
            tick(CPB);
        end
    endtask

    task automatic check_reset_a(input string pfx);
        check_eq({pfx, "_we"}, 32'(a_we), 32'd0);
        check_eq({pfx, "_addr"}, 32'(a_addr), 32'd0);
        check_eq({pfx, "_wdata"}, a_wdata, 32'd0);
        check_eq({pfx, "_hold"}, 32'(a_hold), 32'd1);
        check_eq({pfx, "_done"}, 32'(a_done), 32'd0);
        check_eq({pfx, "_err"}, 32'(a_err), 32'd0);
    endtask

    // Model: word i of an N-word image lands at address i when i < depth; afterwards the
    // address rests at min(N, depth-1) and the image completes iff its checksum is good.
    task automatic send_image(input int sel, input int n, input bit good_chk);
        logic [7:0] bytes[$];
        logic [7:0] x;
        int         depth;
        int         d0;
        int         exp_addr;
        wr_t        w;
        depth = (sel == 0) ? DEPTH_A : DEPTH_B;
        bytes.push_back(8'(n));
        bytes.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(img_words[i][8*k +: 8]);
            end
        end
        x = 8'h00;
        foreach (bytes[i]) x = x ^ bytes[i];
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        bytes.push_back(good_chk ? x : (x ^ 8'h01));
        a_exp_we_prev = 1'b0;
`else
        a_exp_we_prev = (n > 0);
`endif
        for (int i = 0; i < n && i < depth; i++) begin
            w.addr = 32'(i);
            w.data = img_words[i];
            if (sel == 0) exp_a.push_back(w);
            else          exp_b.push_back(w);
        end
        exp_addr = (n == 0) ? 0 : ((n < depth) ? n : depth - 1);
        d0 = (sel == 0) ? a_done_cnt : b_done_cnt;
        foreach (bytes[i]) send_byte(sel, bytes[i]);
        tick(10);
        @(negedge clk);
        if (sel == 0) begin
            check_eq("a_done_count", 32'(a_done_cnt - d0), good_chk ? 32'd1 : 32'd0);
            check_eq("a_pending", 32'(exp_a.size()), 32'd0);
            check_eq("a_hold_after", 32'(a_hold), good_chk ? 32'd0 : 32'd1);
            check_eq("a_addr_after", 32'(a_addr), 32'(exp_addr));
        end else begin
            check_eq("b_done_count", 32'(b_done_cnt - d0), good_chk ? 32'd1 : 32'd0);
            check_eq("b_pending", 32'(exp_b.size()), 32'd0);
            check_eq("b_hold_after", 32'(b_hold), good_chk ? 32'd0 : 32'd1);
            check_eq("b_addr_after", 32'(b_addr), 32'(exp_addr));
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img_words[i] = $urandom();
    endtask

    initial begin
        int n;
        int w0;
        logic [9:0] bad_frame;
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_b = 1'b1;
        tick(3);
        @(negedge clk);
        check_reset_a("rst");
        check_eq("b_rst_hold", 32'(b_hold), 32'd1);
        tick(1);
        rst = 1'b0;

        tick(1000);
        check_eq("idle_no_we", 32'(a_we_cnt), 32'd0);

        img_words[0] = 32'h0000_0013;
        img_words[1] = 32'h0050_00B3;
        send_image(0, 2, 1'b1);

        // Reset in the middle of the fourth payload byte: nothing may be written.
        send_byte(0, 8'h01);
        send_byte(0, 8'h00);
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        send_byte(0, 8'hCC);
        drive_rx(0, 1'b0);
        tick(45);
        rst = 1'b1;
        @(negedge clk);
        check_reset_a("midrst");
        exp_err = 1'b0;
        tick(1);
        rx_a = 1'b1;
        tick(5);
        rst = 1'b0;
        w0 = a_we_cnt;
        tick(300);
        check_eq("midrst_no_we", 32'(a_we_cnt - w0), 32'd0);

        n = int'($urandom_range(1, 4));
        fill_random(n);
        send_image(0, n, 1'b1);

        send_image(0, 0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(1, 4));
            fill_random(n);
            send_image(0, n, 1'b1);
        end

`ifdef UART_IMEM_LOADER_CHECKSUM_EN
        img_words[0] = 32'h0000_0013;
        send_image(0, 1, 1'b0);
        exp_err = 1'b1;
        check_eq("chk_bad_err", 32'(a_err), 32'(exp_err));
        send_image(0, 1, 1'b1);
`endif

        drive_rx(0, 1'b0);
        tick(3);
        drive_rx(0, 1'b1);
        tick(200);
        @(negedge clk);
        check_eq("glitch_hold", 32'(a_hold), 32'd0);
        check_eq("glitch_err", 32'(a_err), 32'(exp_err));

        bad_frame = {1'b0, 8'h3C, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive_rx(0, bad_frame[i]);
            tick(CPB);
        end
        drive_rx(0, 1'b1);
        tick(30);
        @(negedge clk);
        exp_err = 1'b1;
        check_eq("frame_err", 32'(a_err), 32'(exp_err));
        check_eq("frame_hold", 32'(a_hold), 32'd0);

        n = int'($urandom_range(1, 4));
        fill_random(n);
        send_image(0, n, 1'b1);
        check_eq("err_sticky", 32'(a_err), 32'(exp_err));

        fill_random(3);
        send_image(1, 3, 1'b1);
        fill_random(1);
        send_image(1, 1, 1'b1);
        check_eq("b_err", 32'(b_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
